// File: rtl/mem_arbiter_ctrl.sv
// Byte-serial memory arbiter: services icache word fetches and LSB loads/stores
// over one byte-wide RAM port, LSB first, assembling little-endian words.
module mem_arbiter_ctrl #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h30000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear,

    input  logic              ic_enable,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic [31:0]       ic_instr,
    output logic              ic_done,

    input  logic              ls_enable,
    input  logic              ls_wr,
    input  logic [1:0]        ls_len,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_done,

    input  logic [7:0]        ram_din,
    input  logic              io_buffer_full,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout
);

    typedef enum logic [2:0] {IDLE, IFETCH, LOAD, STORE, DONE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [1:0]        len_q, len_n;      // bytes-1 of the active request
    logic [31:0]       wdata_q, wdata_n;
    logic              io_q, io_n;
    logic [2:0]        cnt_q, cnt_n;      // bytes issued so far
    logic [31:0]       acc_q, acc_n;      // read assembly buffer
    logic [ADDR_W-1:0] ram_a_n;
    logic              ram_wr_n;
    logic [7:0]        ram_dout_n;
    logic [31:0]       ic_instr_n, ls_rdata_n;
    logic              ic_done_n, ls_done_n;

    logic [1:0]        ls_len_eff;
    logic [2:0]        n_bytes;
    logic [1:0]        cap_idx;
    logic [31:0]       acc_cap;
    logic              io_stall;

    assign ls_len_eff = (ls_len == 2'd2) ? 2'd3 : ls_len;
    assign n_bytes    = {1'b0, len_q} + 3'd1;
    assign io_stall   = io_q && io_buffer_full;

    // ram_din now answers the address issued one edge ago, i.e. byte cnt-1
    assign cap_idx = cnt_q[1:0] - 2'd1;
    always_comb begin
        acc_cap = acc_q;
        acc_cap[{cap_idx, 3'b000} +: 8] = ram_din;
    end

    always_comb begin
        state_n    = state;
        addr_n     = addr_q;
        len_n      = len_q;
        wdata_n    = wdata_q;
        io_n       = io_q;
        cnt_n      = cnt_q;
        acc_n      = acc_q;
        ram_a_n    = ram_a;
        ram_wr_n   = 1'b0;
        ram_dout_n = ram_dout;
        ic_instr_n = ic_instr;
        ls_rdata_n = ls_rdata;
        ic_done_n  = 1'b0;
        ls_done_n  = 1'b0;

        case (state)
            IDLE: begin
                if (ls_enable) begin
                    addr_n  = ls_addr;
                    len_n   = ls_len_eff;
                    wdata_n = ls_wdata;
                    io_n    = (ls_addr >= IO_BASE);
                    acc_n   = '0;
                    ram_a_n = ls_addr;
                    if (ls_wr) begin
                        state_n = STORE;
                        if ((ls_addr >= IO_BASE) && io_buffer_full) begin
                            cnt_n = 3'd0;
                        end else begin
                            ram_wr_n   = 1'b1;
                            ram_dout_n = ls_wdata[7:0];
                            cnt_n      = 3'd1;
                        end
                    end else begin
                        state_n = LOAD;
                        cnt_n   = 3'd1;
                    end
                end else if (ic_enable && !clear) begin
                    state_n = IFETCH;
                    addr_n  = ic_addr;
                    len_n   = 2'd3;
                    io_n    = 1'b0;
                    acc_n   = '0;
                    ram_a_n = ic_addr;
                    cnt_n   = 3'd1;
                end
            end

            IFETCH, LOAD: begin
                if (state == IFETCH && clear) begin
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                end else begin
                    acc_n = acc_cap;
                    if (cnt_q == n_bytes) begin
                        state_n = DONE;
                        cnt_n   = 3'd0;
                        if (state == IFETCH) begin
                            ic_instr_n = acc_cap;
                            ic_done_n  = 1'b1;
                        end else begin
                            ls_rdata_n = acc_cap;
                            ls_done_n  = 1'b1;
                        end
                    end else begin
                        ram_a_n = addr_q + ADDR_W'(cnt_q);
                        cnt_n   = cnt_q + 3'd1;
                    end
                end
            end

            STORE: begin
                if (cnt_q == n_bytes) begin
                    state_n   = DONE;
                    cnt_n     = 3'd0;
                    ls_done_n = 1'b1;
                end else if (!io_stall) begin
                    ram_a_n    = addr_q + ADDR_W'(cnt_q);
                    ram_dout_n = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    ram_wr_n   = 1'b1;
                    cnt_n      = cnt_q + 3'd1;
                end
            end

            // one dead cycle so the requester can drop its enable
            DONE: state_n = IDLE;

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            wdata_q  <= '0;
            io_q     <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            ram_a    <= '0;
            ram_wr   <= 1'b0;
            ram_dout <= '0;
            ic_instr <= '0;
            ic_done  <= 1'b0;
            ls_rdata <= '0;
            ls_done  <= 1'b0;
        end else if (!rdy) begin
            ram_wr <= 1'b0;
        end else begin
            state    <= state_n;
            addr_q   <= addr_n;
            len_q    <= len_n;
            wdata_q  <= wdata_n;
            io_q     <= io_n;
            cnt_q    <= cnt_n;
            acc_q    <= acc_n;
            ram_a    <= ram_a_n;
            ram_wr   <= ram_wr_n;
            ram_dout <= ram_dout_n;
            ic_instr <= ic_instr_n;
            ic_done  <= ic_done_n;
            ls_rdata <= ls_rdata_n;
            ls_done  <= ls_done_n;
        end
    end

endmodule
